// File: rtl/digout_debug_rx.sv
// Receiver for the single-wire digout debug frame stream: recovers 16-bit words
// and flags sequence, period and framing errors against the expected frame cadence.
module digout_debug_rx #(
  parameter int SYNC_STAGES  = 2,
  parameter int MIN_IDLE     = 8,
  parameter int FRAME_PERIOD = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic [15:0] dout,
  output logic        valid,
  output logic        locked,
  output logic        seq_err,
  output logic        period_err,
  output logic        frame_err,
  output logic [31:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [1:0] ST_HUNT  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int            ZW      = $clog2(MIN_IDLE + 1);
  localparam logic [ZW-1:0] ZMAX    = ZW'(MIN_IDLE);
  localparam logic [7:0]    PER_EXP = 8'(FRAME_PERIOD - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [1:0]             r_state;
  logic [ZW-1:0]          r_zero_cnt;
  logic [7:0]             r_per_cnt;
  logic [3:0]             r_bit_idx;
  logic [15:0]            r_sr;
  logic [15:0]            r_last;
  logic                   w_s;
  logic [15:0]            w_last_inc;

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_last_inc = r_last + 16'd1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_HUNT;
      r_zero_cnt <= '0;
      r_per_cnt  <= '0;
      r_bit_idx  <= '0;
      r_sr       <= '0;
      r_last     <= '0;
      dout       <= '0;
      valid      <= 1'b0;
      locked     <= 1'b0;
      seq_err    <= 1'b0;
      period_err <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      valid      <= 1'b0;
      seq_err    <= 1'b0;
      period_err <= 1'b0;
      frame_err  <= 1'b0;

      if (r_per_cnt != 8'hFF) r_per_cnt <= r_per_cnt + 8'd1;
      if ((seq_err | period_err | frame_err) && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;

      case (r_state)
        ST_HUNT: begin
          if (!w_s) begin
            if (r_zero_cnt != ZMAX) r_zero_cnt <= r_zero_cnt + ZW'(1);
          end else if (r_zero_cnt >= ZMAX) begin
            r_state   <= ST_START;
            r_per_cnt <= '0;
            if (locked && r_per_cnt != PER_EXP) period_err <= 1'b1;
          end else begin
            r_zero_cnt <= '0;
          end
        end
        ST_START: begin
          if (w_s) begin
            r_state   <= ST_DATA;
            r_bit_idx <= '0;
          end else begin
            // A lone '1' is line noise, and the '0' just seen already counts as idle.
            r_state    <= ST_HUNT;
            r_zero_cnt <= ZW'(1);
          end
        end
        ST_DATA: begin
          r_sr      <= {w_s, r_sr[15:1]};
          r_bit_idx <= r_bit_idx + 4'd1;
          if (r_bit_idx == 4'd15) r_state <= ST_STOP;
        end
        default: begin
          r_state <= ST_HUNT;
          if (!w_s) begin
            dout       <= r_sr;
            valid      <= 1'b1;
            frame_cnt  <= frame_cnt + 32'd1;
            r_last     <= r_sr;
            locked     <= 1'b1;
            seq_err    <= locked && (r_sr != w_last_inc);
            r_zero_cnt <= ZW'(1);
          end else begin
            frame_err  <= 1'b1;
            locked     <= 1'b0;
            r_zero_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule
